// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding and
// stream framing constants.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_BYTES = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian word assembler: shifts stream bytes into a 32-bit word and flags
// the transfer that completes it.
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (clear_i) begin
      cnt_q  <= 2'd0;
    end else if (shift_i) begin
      word_q <= {word_q[23:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  // Asserted on the transfer of the final byte, so the word is complete next cycle.
  assign word_ready_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o       = word_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian byte stream into program memory and holds
// the processor in reset until a complete, valid image has been written.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        cpu_reset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int WC_W = $clog2(MEMORY_DEPTH) + 1;

  state_e          state_q;
  logic [WC_W-1:0] wc_q;
  logic [7:0]      len_q;

  logic        xfer;
  logic        start_ok;
  logic        asm_shift;
  logic        asm_clear;
  logic        word_ready;
  logic [31:0] hdr;
  logic [31:0] wc_ext;
  logic [31:0] last_idx;

  assign xfer      = byte_valid_i && byte_ready_o;
  assign start_ok  = start_i && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign asm_shift = byte_valid_i && (state_q == ST_BYTES);
  assign asm_clear = start_ok || (state_q == ST_WRITE);
  assign hdr       = {24'd0, byte_data_i};
  assign wc_ext    = 32'(wc_q);
  assign last_idx  = {24'd0, len_q} - 32'd1;

  program_loader_word_assembler u_word_assembler (
    .clk_i        (clk),
    .rst_i        (reset),
    .clear_i      (asm_clear),
    .shift_i      (asm_shift),
    .byte_i       (byte_data_i),
    .word_o       (mem_data_o),
    .word_ready_o (word_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wc_q    <= '0;
      len_q   <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i) begin
            state_q <= ST_LEN;
            wc_q    <= '0;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            if (hdr == 32'd0 || hdr > 32'(MEMORY_DEPTH)) begin
              state_q <= ST_ERROR;
            end else begin
              len_q   <= byte_data_i;
              state_q <= ST_BYTES;
            end
          end
        end
        ST_BYTES: begin
          if (word_ready) state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (wc_ext == last_idx) begin
            state_q <= ST_DONE;
          end else begin
            wc_q    <= wc_q + 1'b1;
            state_q <= ST_BYTES;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Every handshake/status output is a pure decode of the state register.
  assign byte_ready_o = (state_q == ST_LEN) || (state_q == ST_BYTES);
  assign mem_we_o     = (state_q == ST_WRITE);
  assign busy_o       = (state_q == ST_LEN) || (state_q == ST_BYTES) || (state_q == ST_WRITE);
  assign done_o       = (state_q == ST_DONE);
  assign error_o      = (state_q == ST_ERROR);
  assign cpu_reset_o  = (state_q != ST_DONE);
  assign mem_addr_o   = BASE_ADDRESS + {wc_ext[29:0], 2'b00};

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  byte_data_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_reset_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_in_write = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  program_loader #(.MEMORY_DEPTH(32), .BASE_ADDRESS(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .byte_data_i  (byte_data_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .cpu_reset_o  (cpu_reset_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      wr_addr.push_back(mem_addr_o);
      wr_data.push_back(mem_data_o);
      if (byte_ready_o !== 1'b0) ready_in_write++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit   sent = 0;
    bit   did;
    int   guard = 0;
    while (!sent && guard < 200) begin
      if (gaps && $urandom_range(0, 1) == 0) begin
        byte_valid_i = 1'b0;
      end else begin
        byte_valid_i = 1'b1;
        byte_data_i  = b;
      end
      did = byte_valid_i && (byte_ready_o === 1'b1);
      @(negedge clk);
      if (did) sent = 1;
      guard++;
    end
    byte_valid_i = 1'b0;
    if (!sent) check("byte_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    send_byte(w[31:24], gaps);
    send_byte(w[23:16], gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[7:0], gaps);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_o !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("done_reached", {31'd0, done_o}, 32'd1);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    int t0;
    logic [31:0] bp_words[3];
    bp_words[0] = 32'h0123_4567;
    bp_words[1] = 32'h89AB_CDEF;
    bp_words[2] = 32'hDEAD_BEEF;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("rst_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_error", {31'd0, error_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_data", mem_data_o, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Nominal two-word load with best-case timing
    clear_log();
    t0 = cyc;
    pulse_start();
    check("len_ready", {31'd0, byte_ready_o}, 32'd1);
    check("len_busy", {31'd0, busy_o}, 32'd1);
    send_byte(8'h02, 0);
    send_word(32'h2008_0005, 0);
    send_word(32'h2009_0007, 0);
    wait_done();
    check("nom_latency", cyc - t0, 32'd12);
    check("nom_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
    check("nom_busy", {31'd0, busy_o}, 32'd0);
    check("nom_ready", {31'd0, byte_ready_o}, 32'd0);
    check("nom_nwrites", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check("nom_addr0", wr_addr[0], 32'h0);
      check("nom_data0", wr_data[0], 32'h2008_0005);
      check("nom_addr1", wr_addr[1], 32'h4);
      check("nom_data1", wr_data[1], 32'h2009_0007);
    end

    // Start in DONE reasserts cpu reset; header 0 is rejected
    clear_log();
    pulse_start();
    check("restart_done", {31'd0, done_o}, 32'd0);
    check("restart_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    check("restart_busy", {31'd0, busy_o}, 32'd1);
    send_byte(8'h00, 0);
    check("len0_error", {31'd0, error_o}, 32'd1);
    check("len0_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    check("len0_ready", {31'd0, byte_ready_o}, 32'd0);

    // Header 33 exceeds depth 32
    pulse_start();
    check("restart_error_clr", {31'd0, error_o}, 32'd0);
    send_byte(8'h21, 0);
    check("len33_error", {31'd0, error_o}, 32'd1);
    check("len33_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    check("len33_done", {31'd0, done_o}, 32'd0);
    repeat (2) @(negedge clk);
    check("bad_len_nwrites", wr_addr.size(), 32'd0);

    // Back-pressure: random valid gaps over a 3-word load
    clear_log();
    ready_in_write = 0;
    pulse_start();
    send_byte(8'h03, 1);
    for (int i = 0; i < 3; i++) send_word(bp_words[i], 1);
    wait_done();
    check("bp_nwrites", wr_addr.size(), 32'd3);
    if (wr_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("bp_addr", wr_addr[i], 32'(4 * i));
        check("bp_data", wr_data[i], bp_words[i]);
      end
    end
    check("bp_ready_in_write", ready_in_write, 32'd0);

    // Full depth: 32 words, word value equals its index
    clear_log();
    pulse_start();
    send_byte(8'h20, 0);
    for (int i = 0; i < 32; i++) send_word(32'(i), 0);
    wait_done();
    check("full_nwrites", wr_addr.size(), 32'd32);
    if (wr_addr.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        check("full_addr", wr_addr[i], 32'(4 * i));
        check("full_data", wr_data[i], 32'(i));
      end
      check("full_last_addr", wr_addr[31], 32'h7C);
      check("full_last_data", wr_data[31], 32'h1F);
    end
    check("full_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);

    // Reset mid-load after the second byte of word 1
    clear_log();
    pulse_start();
    send_byte(8'h02, 0);
    send_word(32'h1111_2222, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    check("mid_rst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("mid_rst_we", {31'd0, mem_we_o}, 32'd0);
    check("mid_rst_addr", mem_addr_o, 32'h0);
    check("mid_rst_data", mem_data_o, 32'h0);
    check("mid_rst_done", {31'd0, done_o}, 32'd0);
    check("mid_rst_error", {31'd0, error_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_word(32'hCAFE_F00D, 0);
    wait_done();
    check("post_rst_nwrites", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("post_rst_addr", wr_addr[0], 32'h0);
      check("post_rst_data", wr_data[0], 32'hCAFE_F00D);
    end

    // Start pulse while busy is ignored
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    pulse_start();
    check("busy_start_busy", {31'd0, busy_o}, 32'd1);
    check("busy_start_ready", {31'd0, byte_ready_o}, 32'd1);
    send_byte(8'hC3, 0);
    send_byte(8'h3C, 0);
    wait_done();
    check("busy_start_nwrites", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("busy_start_addr", wr_addr[0], 32'h0);
      check("busy_start_data", wr_data[0], 32'hA55A_C33C);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the instruction memory that the single-cycle MIPS core fetches from. It accepts a length-prefixed byte stream from a host link, such as a UART receiver, and assembles big-endian 32-bit instruction words. It writes those words to consecutive word addresses of the program memory write port. While a load runs it holds the processor in reset, and it releases the processor only after a complete, valid image has been written.

## Interface
Parameters:
- MEMORY_DEPTH, 32, capacity of program memory in 32-bit words; the maximum legal length header.
- BASE_ADDRESS, 32'h0000_0000, byte address of the first written word; must be word-aligned.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_data_i  in  8  stream byte.
- byte_valid_i  in  1  byte_data_i is valid.
- byte_ready_o  out  1  loader accepts a byte this cycle; a transfer occurs when valid and ready are both 1.
- mem_we_o  out  1  program memory write strobe; one cycle per word.
- mem_addr_o  out  32  byte address of the word being written.
- mem_data_o  out  32  instruction word being written.
- cpu_reset_o  out  1  held-reset for the processor; 1 = core held.
- busy_o  out  1  load in progress (LEN, BYTES or WRITE).
- done_o  out  1  last load completed successfully; level signal.
- error_o  out  1  last load was rejected because of a bad length; level signal.

## Operation
- Stream format: one length byte N, then 4·N bytes, most-significant byte of each word first.
- FSM states: IDLE, LEN, BYTES, WRITE, DONE, ERROR.
  - IDLE/DONE/ERROR → LEN on start_i. Entering LEN clears done_o/error_o, sets cpu_reset_o=1, and clears the word counter and the byte counter.
  - LEN: byte_ready_o=1. On transfer:
    - N==0 or N>MEMORY_DEPTH → ERROR.
    - Otherwise latch N → BYTES.
  - BYTES: byte_ready_o=1. Each transfer shifts the byte into a 32-bit assembly register (shift left by 8 and OR in the byte). On the 4th byte → WRITE.
  - WRITE: byte_ready_o=0. Drives mem_we_o=1, mem_addr_o=BASE_ADDRESS+4·word_count, mem_data_o=assembled word. Next state:
    - if word_count==N-1 → DONE;
    - else increment word_count, clear the byte counter → BYTES.
  - DONE: done_o=1, cpu_reset_o=0, byte_ready_o=0.
  - ERROR: error_o=1, cpu_reset_o stays 1, byte_ready_o=0. Previously written words are not erased.
- Bytes presented while byte_ready_o=0 are not consumed and are not lost; the sender holds them.
- A start_i pulse while busy_o=1 is ignored.
- start_i is not self-clearing; the loader acts only on a pulse seen in IDLE/DONE/ERROR.
- The word counter is log2(MEMORY_DEPTH)+1 bits wide, so N==MEMORY_DEPTH never wraps. Address arithmetic is 32-bit unsigned.

## Timing
- Reset (asynchronous):
  - state = IDLE;
  - cpu_reset_o = 1;
  - byte_ready_o, mem_we_o, busy_o, done_o, error_o = 0;
  - mem_addr_o = BASE_ADDRESS;
  - mem_data_o = 0.
- All outputs are registered or decoded from the state register only. No combinational path runs from byte_valid_i to byte_ready_o.
- start_i in cycle t → LEN in cycle t+1, with byte_ready_o=1 at t+1.
- Best-case throughput is 5 cycles per word (4 byte transfers plus 1 WRITE). Total best-case load = 1 + 1 + 5·N cycles from start_i to done_o.
- mem_we_o is high for exactly one cycle per word. The write completes at the rising edge that ends the WRITE cycle.
- cpu_reset_o falls in the same cycle done_o rises, i.e. the cycle after the final WRITE. The core's first fetch therefore sees the fully written memory.
- A reset asserted mid-load aborts immediately. The partial image is left in memory, and cpu_reset_o returns to 1.

## Structure
- Shared package holds the state encoding constants (3-bit, 6 states) and the stream framing constant BYTES_PER_WORD=4.
- One natural sub-module: word_assembler. It is a 4-byte shift register with a 2-bit byte counter, a clear input and a word_ready flag. The FSM, the address and word counters, and the handshake stay in program_loader.

## Test plan
- Nominal load: reset, start_i, stream 02,20,08,00,05,20,09,00,07 → writes 0x20080005 @0x0 and 0x20090007 @0x4, one mem_we_o cycle each. done_o=1 and cpu_reset_o=0 exactly 12 cycles after start_i.
- Bad length: stream header 00, then separately header 33 (MEMORY_DEPTH=32) → ERROR both times. No mem_we_o, error_o=1, cpu_reset_o=1.
- Back-pressure/gaps: toggle byte_valid_i randomly during a 3-word load → identical writes and addresses, and no byte dropped or duplicated. byte_ready_o=0 during every WRITE cycle.
- Full depth: N=32 with the word value equal to its index → last write goes to 0x7C with data 0x0000001F, then done_o=1 and no counter wrap.
- Reset mid-operation: assert reset after the 2nd byte of word 1 → all outputs return to reset values in the same cycle. A new start_i with N=1 then loads correctly at BASE_ADDRESS.
- Start while busy: pulse start_i during BYTES → ignored, and the load completes unchanged. A start_i in DONE reasserts cpu_reset_o the next cycle and clears done_o.
